cordic_rot_engine: RTL and testbench

- Iterative rotation-mode CORDIC engine.
- Reads the arctangent table ROM (5-bit address, 32-bit unsigned data, 30 fractional bits, entry i = atan(2^-i)) once per iteration.
- Produces cos/sin of a Q2.30 input angle.
- Sits between the angle source and downstream consumers; it is the reader side of the ROM's combinational address/data interface.

---
 rtl/cordic_rot_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_cordic_rot_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rot_engine.sv
// Iterative rotation-mode CORDIC: cos/sin of a signed Q2.30 angle.
// One micro-rotation per clock; the arctangent ROM is read combinationally
// through rom_addr/rom_data. Optional angle range check: define
// CORDIC_RANGE_CHECK_EN to reject |angle| > pi/2 with out_err.
module cordic_rot_engine #(
    parameter int unsigned      WIDTH  = 32,
    parameter int unsigned      FRAC   = 30,
    parameter int unsigned      ITER   = 16,
    parameter logic [WIDTH-1:0] K_INIT = WIDTH'(32'h26DD3B6A)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_angle,
    output logic [4:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_cos,
    output logic [WIDTH-1:0] out_sin,
    output logic             out_err
);

    localparam int unsigned      AW        = 5;
    localparam logic [AW-1:0]    LAST_ITER = AW'(ITER - 1);
    // Table entries are all below 1.0, so only the fraction bits carry weight.
    localparam logic [WIDTH-1:0] FRAC_MASK = WIDTH'((64'd1 << FRAC) - 64'd1);

`ifdef CORDIC_RANGE_CHECK_EN
    localparam logic signed [WIDTH-1:0] HALF_PI     = WIDTH'(32'sh6487ED51);
    localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef CORDIC_RANGE_CHECK_EN
        ,
        S_REJ  = 2'd3
`endif
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic signed [WIDTH-1:0]  r_x;
    logic signed [WIDTH-1:0]  r_y;
    logic signed [WIDTH-1:0]  r_z;
    logic        [AW-1:0]     r_iter;
    logic        [WIDTH-1:0]  r_cos;
    logic        [WIDTH-1:0]  r_sin;
    logic                     r_out_valid;
    logic                     r_in_ready;

    logic signed [WIDTH-1:0]  w_x_nxt;
    logic signed [WIDTH-1:0]  w_y_nxt;
    logic signed [WIDTH-1:0]  w_z_nxt;
    logic        [AW-1:0]     w_iter_nxt;
    logic        [WIDTH-1:0]  w_cos_nxt;
    logic        [WIDTH-1:0]  w_sin_nxt;
    logic                     w_out_valid_nxt;
    logic                     w_in_ready_nxt;

    logic signed [WIDTH-1:0]  w_x_sh;
    logic signed [WIDTH-1:0]  w_y_sh;
    logic        [WIDTH-1:0]  w_rom_mag;
    logic                     w_d_pos;
    logic signed [WIDTH-1:0]  w_x_rot;
    logic signed [WIDTH-1:0]  w_y_rot;
    logic signed [WIDTH-1:0]  w_z_rot;

`ifdef CORDIC_RANGE_CHECK_EN
    logic                     r_err;
    logic                     w_err_nxt;
    logic                     w_out_of_range;
`endif

    // One micro-rotation: direction taken from the sign of the residual angle.
    assign w_x_sh    = r_x >>> r_iter;
    assign w_y_sh    = r_y >>> r_iter;
    assign w_rom_mag = rom_data & FRAC_MASK;
    assign w_d_pos   = ~r_z[WIDTH-1];
    assign w_x_rot   = w_d_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_rot   = w_d_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_rot   = w_d_pos ? (r_z - $signed(w_rom_mag)) : (r_z + $signed(w_rom_mag));

`ifdef CORDIC_RANGE_CHECK_EN
    assign w_out_of_range = ($signed(in_angle) > HALF_PI) || ($signed(in_angle) < NEG_HALF_PI);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_z_nxt         = r_z;
        w_iter_nxt      = r_iter;
        w_cos_nxt       = r_cos;
        w_sin_nxt       = r_sin;
        w_out_valid_nxt = r_out_valid;
        w_in_ready_nxt  = r_in_ready;
`ifdef CORDIC_RANGE_CHECK_EN
        w_err_nxt       = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_in_ready_nxt = 1'b0;
                    w_iter_nxt     = '0;
`ifdef CORDIC_RANGE_CHECK_EN
                    if (w_out_of_range) begin
                        w_state_nxt = S_REJ;
                    end else begin
                        w_x_nxt     = $signed(K_INIT);
                        w_y_nxt     = '0;
                        w_z_nxt     = $signed(in_angle);
                        w_state_nxt = S_RUN;
                    end
`else
                    w_x_nxt     = $signed(K_INIT);
                    w_y_nxt     = '0;
                    w_z_nxt     = $signed(in_angle);
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                w_x_nxt = w_x_rot;
                w_y_nxt = w_y_rot;
                w_z_nxt = w_z_rot;
                if (r_iter == LAST_ITER) begin
                    w_cos_nxt       = w_x_rot;
                    w_sin_nxt       = w_y_rot;
                    w_out_valid_nxt = 1'b1;
                    w_iter_nxt      = '0;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_iter_nxt = r_iter + AW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
`ifdef CORDIC_RANGE_CHECK_EN
                    w_err_nxt       = 1'b0;
`endif
                    w_state_nxt     = S_IDLE;
                end
            end
`ifdef CORDIC_RANGE_CHECK_EN
            S_REJ: begin
                w_cos_nxt       = '0;
                w_sin_nxt       = '0;
                w_err_nxt       = 1'b1;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_DONE;
            end
`endif
            default: begin
                w_state_nxt     = S_IDLE;
                w_iter_nxt      = '0;
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_iter      <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_z         <= w_z_nxt;
            r_iter      <= w_iter_nxt;
            r_cos       <= w_cos_nxt;
            r_sin       <= w_sin_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

`ifdef CORDIC_RANGE_CHECK_EN
    // Rejection flag, held until the result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

    // The iteration counter is zero outside RUN, so it doubles as the ROM address.
    assign rom_addr  = r_iter;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_cos   = r_cos;
    assign out_sin   = r_sin;

endmodule

// File: tb/tb_cordic_rot_engine.sv
// Randomized self-checking bench for cordic_rot_engine with a behavioural
// CORDIC model and a floating-point accuracy check.
module tb_cordic_rot_engine;

    localparam int ITER  = 16;
    localparam int WIDTH = 32;
    localparam logic [31:0] K_INIT = 32'h26DD3B6A;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_angle = '0;
    logic [4:0]       rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_cos;
    logic [WIDTH-1:0] out_sin;
    logic             out_err;

    logic [31:0] rom [32];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    cordic_rot_engine #(.WIDTH(WIDTH), .FRAC(30), .ITER(ITER), .K_INIT(K_INIT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cos(out_cos), .out_sin(out_sin), .out_err(out_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the CORDIC recurrence on plain 32-bit integers.
    task automatic model(input logic [31:0] ang, output logic [31:0] c, output logic [31:0] s);
        int x;
        int y;
        int z;
        int xs;
        int ys;
        x = int'(K_INIT);
        y = 0;
        z = int'(ang);
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - int'(rom[i]);
            end else begin
                x = x + ys; y = y - xs; z = z + int'(rom[i]);
            end
        end
        c = 32'(x);
        s = 32'(y);
    endtask

    function automatic bit near(input logic [31:0] got, input real v);
        longint g;
        longint e;
        longint d;
        g = longint'($signed(got));
        e = longint'(v * 1073741824.0);
        d = g - e;
        return (d <= 64'sd65536) && (d >= -64'sd65536);
    endfunction

    // Run one transaction: checks rom_addr sequence, latency, back-pressure
    // stability and the handshake; returns the result.
    task automatic do_op(input logic [31:0] ang, input int hold, input int exp_lat,
                         input bit addr_runs, output logic [31:0] c,
                         output logic [31:0] s, output logic e);
        int n;
        int cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = ang;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 200), 64'd1);
        @(posedge clk);
        cnt = 0;
        while (cnt < exp_lat + 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            cnt++;
            if (out_valid) break;
            check("rom_addr", 64'(rom_addr), addr_runs ? 64'(cnt - 1) : 64'd0);
        end
        check("latency", 64'(cnt), 64'(exp_lat));
        c = out_cos;
        s = out_sin;
        e = out_err;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_angle = $urandom;
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ready", 64'(in_ready), 64'd0);
            check("hold_cos", 64'(out_cos), 64'(c));
            check("hold_sin", 64'(out_sin), 64'(s));
            check("hold_addr", 64'(rom_addr), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_valid", 64'(out_valid), 64'd0);
        check("hs_ready", 64'(in_ready), 64'd1);
        check("hs_err", 64'(out_err), 64'd0);
    endtask

    task automatic run_checked(input string tag, input logic [31:0] ang, input int hold);
        logic [31:0] c;
        logic [31:0] s;
        logic [31:0] mc;
        logic [31:0] ms;
        logic        e;
        real         a;
        do_op(ang, hold, ITER + 1, 1'b1, c, s, e);
        model(ang, mc, ms);
        a = real'($signed(ang)) / 1073741824.0;
        check({tag, "_cos"}, 64'(c), 64'(mc));
        check({tag, "_sin"}, 64'(s), 64'(ms));
        check({tag, "_err"}, 64'(e), 64'd0);
        check({tag, "_cos_acc"}, 64'(near(c, $cos(a))), 64'd1);
        check({tag, "_sin_acc"}, 64'(near(s, $sin(a))), 64'd1);
    endtask

    initial begin
        real p;
        logic [31:0] c;
        logic [31:0] s;
        logic        e;
        longint      r;
        int          n;

        p = 1.0;
        for (int i = 0; i < 32; i++) begin
            rom[i] = 32'(longint'($atan(p) * 1073741824.0));
            p = p / 2.0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_cos", 64'(out_cos), 64'd0);
        check("rst_sin", 64'(out_sin), 64'd0);
        check("rst_addr", 64'(rom_addr), 64'd0);
        rst = 1'b0;

        // out_ready while idle has no effect
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ordy_valid", 64'(out_valid), 64'd0);
        check("idle_ordy_ready", 64'(in_ready), 64'd1);

        // Directed angles from the plan
        run_checked("zero", 32'h0000_0000, 0);
        check("zero_cos_abs", 64'(near(out_cos, 1.0)), 64'd1);
        run_checked("pi4", 32'h3243F6A8, 0);
        check("pi4_eq", 64'(near(out_cos, 759250125.0 / 1073741824.0)), 64'd1);
        run_checked("pi6", 32'd562209904, 10);
        run_checked("npi6", 32'(-32'sd562209904), 0);
        run_checked("hpi", 32'h6487ED51, 0);
        run_checked("nhpi", 32'h9B7812AF, 0);

        // Randomized in-range angles, some with back-pressure
        for (int t = 0; t < 20; t++) begin
            r = longint'($urandom_range(32'hC90FDAA2, 0)) - 64'sh6487ED51;
            run_checked("rand", 32'(r), int'($urandom_range(3, 0)));
        end

        // Reset in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = 32'h1234_5678;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_addr", 64'(rom_addr), 64'd7);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_addr", 64'(rom_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (ITER + 3) begin
            @(negedge clk);
            check("mid_no_result", 64'(out_valid), 64'd0);
        end
        run_checked("post_rst", 32'h2000_0000, 0);

        // Out-of-range angle
`ifdef CORDIC_RANGE_CHECK_EN
        do_op(32'h7000_0000, 2, 2, 1'b0, c, s, e);
        check("oor_err", 64'(e), 64'd1);
        check("oor_cos", 64'(c), 64'd0);
        check("oor_sin", 64'(s), 64'd0);
        do_op(32'h9000_0000, 0, 2, 1'b0, c, s, e);
        check("noor_err", 64'(e), 64'd1);
        run_checked("after_oor", 32'h1000_0000, 0);
`else
        do_op(32'h7000_0000, 0, ITER + 1, 1'b1, c, s, e);
        check("oor_err", 64'(e), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
